// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, halt opcodes
// and the {pc, instr} queue entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HALT
    } fetch_state_t;

    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int unsigned FETCH_XLEN = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt_op(input logic [6:0] opc);
        return (opc == OPC_FENCE) || (opc == OPC_SYSTEM);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; pointers wrap naturally because
// DEPTH is a power of two.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues one word request at a time and
// queues {pc, instr} toward IF/ID. FETCH_BYPASS_EN enables an empty-queue bypass.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            halted
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic            halted_q, halted_d;

    logic [AW:0]       count, count_nxt;
    logic [2*XLEN-1:0] head;
    logic              hs, rsp_take, bypass, push, pop, outstanding;

    assign hs       = req_valid_q && imem_req_ready;
    assign rsp_take = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_take && (count == '0);
`else
    assign bypass = 1'b0;
`endif
    assign push = rsp_take && !(bypass && out_ready);
    assign pop  = (count != '0) && out_ready && !redirect_valid;

    // A response that lands in the redirect cycle settles the request, so only
    // an unanswered one forces the discard state.
    assign outstanding = ((state_q == S_REQ) && hs) ||
                         (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_rsp_valid);

    always_comb begin
        count_nxt = count;
        if (redirect_valid) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            fpc_d   = redirect_pc & ~XLEN'(3);
            state_d = outstanding ? S_DISCARD : S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (hs) begin
                        fpc_d    = fpc_q + XLEN'(4);
                        req_pc_d = fpc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = is_halt_op(imem_rsp_data[6:0]) ? S_HALT : S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_REQ;
            endcase
        end
        req_valid_d = (state_d == S_REQ) && (count_nxt < FULL_CNT);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            fpc_q       <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            halted_q    <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2*XLEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({req_pc_q, imem_rsp_data}),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fpc_q;
    assign halted         = halted_q;
    assign out_valid      = (count != '0) || bypass;
    assign out_pc         = bypass ? req_pc_q      : head[2*XLEN-1:XLEN];
    assign out_instr      = bypass ? imem_rsp_data : head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a cycle table plus hand sequences
// for queue fill/drain, reset mid-request, PC wrap and the optional bypass.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;

    fetch_prefetch_queue #(
        .DEPTH(4),
        .XLEN(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        auto_mem = 1'b0;
    logic        last_hs  = 1'b0;
    logic [31:0] last_addr = '0;

    typedef struct packed {
        logic        rdy;
        logic        ordy;
        logic        rspv;
        logic [31:0] rspd;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ehalt;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic rdy, input logic ordy, input logic rspv,
                                 input logic [31:0] rspd, input logic redir, input logic [31:0] rpc,
                                 input logic ereq, input logic [31:0] eaddr, input logic eov,
                                 input logic [31:0] epc, input logic [31:0] einstr, input logic ehalt);
        vec_t v;
        v.rdy = rdy;   v.ordy = ordy;   v.rspv = rspv;   v.rspd = rspd;
        v.redir = redir; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.eov = eov; v.epc = epc;
        v.einstr = einstr; v.ehalt = ehalt;
        return v;
    endfunction

    // Non-halting I-type encoding derived from the address.
    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return {a[24:0], 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs are observed 1ns later, before the next posedge.
    task automatic drive(input logic rdy, input logic ordy, input logic rspv,
                         input logic [31:0] rspd, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (auto_mem) begin
            imem_rsp_valid = last_hs;
            imem_rsp_data  = last_hs ? mk_instr(last_addr) : 32'h0;
        end else begin
            imem_rsp_valid = rspv;
            imem_rsp_data  = rspd;
        end
        #1;
        last_hs   = imem_req_valid && imem_req_ready;
        last_addr = imem_req_addr;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        auto_mem       = 1'b0;
        last_hs        = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   issued;
        vec_t v;

        // rdy ordy rspv rspd          redir rpc   | req addr  ov pc     instr        halt
        tbl[0]  = mkv(1,1,0,32'h0,        0,32'h0,  0,32'h00,0,32'h00,32'h0,       0);
        tbl[1]  = mkv(1,1,0,32'h0,        0,32'h0,  1,32'h00,0,32'h00,32'h0,       0);
        tbl[2]  = mkv(1,1,1,32'h13,       0,32'h0,  0,32'h04,0,32'h00,32'h0,       0);
        tbl[3]  = mkv(1,1,0,32'h0,        0,32'h0,  1,32'h04,1,32'h00,32'h13,      0);
        tbl[4]  = mkv(1,1,1,32'h00100093, 0,32'h0,  0,32'h08,0,32'h00,32'h0,       0);
        tbl[5]  = mkv(1,0,0,32'h0,        0,32'h0,  1,32'h08,1,32'h04,32'h00100093,0);
        tbl[6]  = mkv(1,0,1,32'h0000000F, 0,32'h0,  0,32'h0C,1,32'h04,32'h00100093,0);
        tbl[7]  = mkv(1,0,0,32'h0,        0,32'h0,  0,32'h0C,1,32'h04,32'h00100093,1);
        tbl[8]  = mkv(1,1,1,32'hDEADBEEF, 0,32'h0,  0,32'h0C,1,32'h04,32'h00100093,1);
        tbl[9]  = mkv(1,1,0,32'h0,        0,32'h0,  0,32'h0C,1,32'h08,32'h0000000F,1);
        tbl[10] = mkv(1,1,0,32'h0,        0,32'h0,  0,32'h0C,0,32'h00,32'h0,       1);
        tbl[11] = mkv(1,1,0,32'h0,        1,32'h22, 0,32'h0C,0,32'h00,32'h0,       1);
        tbl[12] = mkv(0,1,0,32'h0,        0,32'h0,  1,32'h20,0,32'h00,32'h0,       0);
        tbl[13] = mkv(1,1,0,32'h0,        0,32'h0,  1,32'h20,0,32'h00,32'h0,       0);
        tbl[14] = mkv(1,1,0,32'h0,        1,32'h40, 0,32'h24,0,32'h00,32'h0,       0);
        tbl[15] = mkv(1,1,1,32'h11111113, 0,32'h0,  0,32'h40,0,32'h00,32'h0,       0);
        tbl[16] = mkv(1,1,0,32'h0,        0,32'h0,  1,32'h40,0,32'h00,32'h0,       0);
        tbl[17] = mkv(1,1,1,32'h00200113, 0,32'h0,  0,32'h44,0,32'h00,32'h0,       0);
        tbl[18] = mkv(0,1,0,32'h0,        0,32'h0,  1,32'h44,1,32'h40,32'h00200113,0);
        tbl[19] = mkv(1,0,0,32'h0,        0,32'h0,  1,32'h44,0,32'h00,32'h0,       0);
        tbl[20] = mkv(1,0,1,32'h00300193, 0,32'h0,  0,32'h48,0,32'h00,32'h0,       0);
        tbl[21] = mkv(1,1,0,32'h0,        1,32'h80, 1,32'h48,1,32'h44,32'h00300193,0);
        tbl[22] = mkv(1,1,0,32'h0,        0,32'h0,  0,32'h80,0,32'h00,32'h0,       0);
        tbl[23] = mkv(1,1,1,32'h44444444, 0,32'h0,  0,32'h80,0,32'h00,32'h0,       0);
        tbl[24] = mkv(0,1,0,32'h0,        0,32'h0,  1,32'h80,0,32'h00,32'h0,       0);

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        #2;
        chk("reset req_valid", 32'(imem_req_valid), 32'h0);
        chk("reset req_addr",  imem_req_addr,       32'h0);
        chk("reset out_valid", 32'(out_valid),      32'h0);
        chk("reset out_pc",    out_pc,              32'h0);
        chk("reset out_instr", out_instr,           32'h0);
        chk("reset halted",    32'(halted),         32'h0);

        // Basic fetch, halt on FENCE, redirect out of halt and out of S_WAIT.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            drive(v.rdy, v.ordy, v.rspv, v.rspd, v.redir, v.rpc);
            chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(v.ereq));
            chk($sformatf("v%0d req_addr", i),  imem_req_addr,       v.eaddr);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid),      32'(v.eov));
            chk($sformatf("v%0d halted", i),    32'(halted),         32'(v.ehalt));
            if (v.eov) begin
                chk($sformatf("v%0d out_pc", i),    out_pc,    v.epc);
                chk($sformatf("v%0d out_instr", i), out_instr, v.einstr);
            end
        end

        // ID stall: exactly four entries queue up, then drain in order.
        do_reset();
        auto_mem = 1'b1;
        issued   = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (last_hs) issued++;
        end
        chk("fill issued",    32'(issued),          32'd4);
        chk("fill req_valid", 32'(imem_req_valid),  32'h0);
        chk("fill out_valid", 32'(out_valid),       32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("drain%0d out_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("drain%0d out_pc", i),    out_pc,         32'(4 * i));
            chk($sformatf("drain%0d out_instr", i), out_instr,      mk_instr(32'(4 * i)));
        end

        // Request held under backpressure, then reset while a response is owed.
        do_reset();
        auto_mem = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("hold first req_valid", 32'(imem_req_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("hold%0d req_valid", i), 32'(imem_req_valid), 32'h1);
            chk($sformatf("hold%0d req_addr", i),  imem_req_addr,       32'h0);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pre-rst req_addr", imem_req_addr, 32'h4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst req_addr",  imem_req_addr,       32'h0);
        chk("midrst out_valid", 32'(out_valid),      32'h0);
        chk("midrst halted",    32'(halted),         32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stale rsp seen",     32'(imem_rsp_valid), 32'h1);
        chk("postrst req_valid0", 32'(imem_req_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("postrst req_valid1", 32'(imem_req_valid), 32'h1);
        chk("postrst req_addr",   imem_req_addr,       32'h0);
        chk("postrst out_valid",  32'(out_valid),      32'h0);

        // Fetch PC wraps from the top of the address space to zero.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap req_valid", 32'(imem_req_valid), 32'h1);
        chk("wrap req_addr",  imem_req_addr,       32'hFFFFFFFC);
        drive(1'b0, 1'b0, 1'b1, 32'h00000013, 1'b0, 32'h0);
        chk("wrap next addr", imem_req_addr,       32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap out_valid", 32'(out_valid),      32'h1);
        chk("wrap out_pc",    out_pc,              32'hFFFFFFFC);
        chk("wrap req_valid2", 32'(imem_req_valid), 32'h1);

`ifdef FETCH_BYPASS_EN
        // Response into an empty queue is visible the same cycle and consumed directly.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h0);
        chk("byp out_valid", 32'(out_valid), 32'h1);
        chk("byp out_pc",    out_pc,         32'h0);
        chk("byp out_instr", out_instr,      32'h00000013);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("byp after out_valid", 32'(out_valid),      32'h0);
        chk("byp after req_valid", 32'(imem_req_valid), 32'h1);
        chk("byp after req_addr",  imem_req_addr,       32'h4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
